// File: rtl/id_pipe.sv
// -----------------------------------------------------------------------------
// id_pipe -- instruction decode stage with operand forwarding, load-use hazard
// detection and a single registered ID/EX payload slot with valid/ready
// handshakes on both sides.
//
// Configuration macro: ID_PIPE_FWD_EN
//   defined   : operands may be taken from the forwarding sources; a hazard is
//               raised only when the selected source still has its data pending.
//   undefined : operands come from the regfile only; any forwarding-source
//               write to a register being read is treated as a hazard.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   in_valid / in_ready      upstream handshake for pc_i / inst_i
//   reg{1,2}_read_o/addr_o   regfile read requests (combinational from inst_i)
//   reg{1,2}_data_i          regfile read data
//   fwd_wreg_i/wd_i/wdata_i/pend_i   forwarding sources, index 0 youngest
//   out_valid / out_ready    downstream handshake for the registered payload
//   aluop_o, alusel_o, reg1_o, reg2_o, wd_o, wreg_o, pc_o, inst_invalid_o
//                            registered ID/EX payload
//   stall_o                  combinational hazard stall towards fetch
// -----------------------------------------------------------------------------
module id_pipe #(
   parameter int DATA_W  = 32,
   parameter int NUM_FWD = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [31:0]               pc_i,
   input  logic [31:0]               inst_i,
   output logic                      reg1_read_o,
   output logic                      reg2_read_o,
   output logic [4:0]                reg1_addr_o,
   output logic [4:0]                reg2_addr_o,
   input  logic [DATA_W-1:0]         reg1_data_i,
   input  logic [DATA_W-1:0]         reg2_data_i,
   input  logic [NUM_FWD-1:0]        fwd_wreg_i,
   input  logic [5*NUM_FWD-1:0]      fwd_wd_i,
   input  logic [DATA_W*NUM_FWD-1:0] fwd_wdata_i,
   input  logic [NUM_FWD-1:0]        fwd_pend_i,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [7:0]                aluop_o,
   output logic [2:0]                alusel_o,
   output logic [DATA_W-1:0]         reg1_o,
   output logic [DATA_W-1:0]         reg2_o,
   output logic [4:0]                wd_o,
   output logic                      wreg_o,
   output logic [31:0]               pc_o,
   output logic                      inst_invalid_o,
   output logic                      stall_o
);

   if (DATA_W < 32) begin : g_bad_width
      $error("id_pipe: DATA_W must be at least 32");
   end

   // opcode / funct / ALU encodings (MIPS OpenMIPS defines)
   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_ANDI    = 6'b001100;
   localparam logic [5:0] OP_ORI     = 6'b001101;
   localparam logic [5:0] OP_XORI    = 6'b001110;
   localparam logic [5:0] OP_LUI     = 6'b001111;
   localparam logic [5:0] FN_AND     = 6'b100100;
   localparam logic [5:0] FN_OR      = 6'b100101;
   localparam logic [5:0] FN_XOR     = 6'b100110;
   localparam logic [5:0] FN_NOR     = 6'b100111;
   localparam logic [7:0] ALU_NOP    = 8'b00000000;
   localparam logic [7:0] ALU_AND    = 8'b00100100;
   localparam logic [7:0] ALU_OR     = 8'b00100101;
   localparam logic [7:0] ALU_XOR    = 8'b00100110;
   localparam logic [7:0] ALU_NOR    = 8'b00100111;
   localparam logic [2:0] SEL_NOP    = 3'b000;
   localparam logic [2:0] SEL_LOGIC  = 3'b001;

   typedef struct packed {
      logic [7:0]        aluop;
      logic [2:0]        alusel;
      logic [DATA_W-1:0] reg1;
      logic [DATA_W-1:0] reg2;
      logic [4:0]        wd;
      logic              wreg;
      logic [31:0]       pc;
      logic              invalid;
   } pay_t;

   pay_t pay_d, pay_q;
   logic vld_d, vld_q;

   // ---------------------------------------------------------------- decode
   logic [5:0]        op, funct;
   logic [4:0]        rs, rt, rd, shamt;
   logic [7:0]        dec_aluop;
   logic [2:0]        dec_alusel;
   logic              rd1, rd2, dec_wreg, dec_inv;
   logic [4:0]        dec_wd;
   logic [DATA_W-1:0] imm1, imm2;

   assign op    = inst_i[31:26];
   assign rs    = inst_i[25:21];
   assign rt    = inst_i[20:16];
   assign rd    = inst_i[15:11];
   assign shamt = inst_i[10:6];
   assign funct = inst_i[5:0];

   always_comb begin
      dec_aluop  = ALU_NOP;
      dec_alusel = SEL_NOP;
      rd1        = 1'b0;
      rd2        = 1'b0;
      dec_wreg   = 1'b0;
      dec_wd     = 5'd0;
      dec_inv    = 1'b1;
      imm1       = '0;
      imm2       = '0;
      case (op)
         OP_ORI, OP_ANDI, OP_XORI: begin
            dec_aluop  = (op == OP_ORI)  ? ALU_OR :
                         (op == OP_ANDI) ? ALU_AND : ALU_XOR;
            dec_alusel = SEL_LOGIC;
            rd1        = 1'b1;
            imm2       = DATA_W'(inst_i[15:0]);
            dec_wd     = rt;
            dec_wreg   = 1'b1;
            dec_inv    = 1'b0;
         end
         OP_LUI: begin
            dec_aluop  = ALU_OR;
            dec_alusel = SEL_LOGIC;
            imm1       = DATA_W'({inst_i[15:0], 16'h0000});
            dec_wd     = rt;
            dec_wreg   = 1'b1;
            dec_inv    = 1'b0;
         end
         OP_SPECIAL: begin
            if (inst_i == 32'h0) begin
               // canonical NOP: no effect but not an illegal encoding
               dec_inv = 1'b0;
            end else if (shamt == 5'd0 &&
                         (funct == FN_OR  || funct == FN_AND ||
                          funct == FN_XOR || funct == FN_NOR)) begin
               dec_aluop  = {2'b00, funct};
               dec_alusel = SEL_LOGIC;
               rd1        = 1'b1;
               rd2        = 1'b1;
               dec_wd     = rd;
               dec_wreg   = 1'b1;
               dec_inv    = 1'b0;
            end
         end
         default: ;
      endcase
   end

   assign reg1_read_o = rd1;
   assign reg2_read_o = rd2;
   assign reg1_addr_o = rs;
   assign reg2_addr_o = rt;

   // ------------------------------------------------------- forwarding match
   // Walk from oldest to youngest so the lowest matching index wins.
   logic hit1, hit2;
`ifdef ID_PIPE_FWD_EN
   logic              pend1, pend2;
   logic [DATA_W-1:0] fdat1, fdat2;
`endif

   always_comb begin
      hit1 = 1'b0;
      hit2 = 1'b0;
`ifdef ID_PIPE_FWD_EN
      pend1 = 1'b0;
      pend2 = 1'b0;
      fdat1 = '0;
      fdat2 = '0;
`endif
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
         if (fwd_wreg_i[i] && fwd_wd_i[5*i +: 5] == rs) begin
            hit1 = 1'b1;
`ifdef ID_PIPE_FWD_EN
            pend1 = fwd_pend_i[i];
            fdat1 = fwd_wdata_i[DATA_W*i +: DATA_W];
`endif
         end
         if (fwd_wreg_i[i] && fwd_wd_i[5*i +: 5] == rt) begin
            hit2 = 1'b1;
`ifdef ID_PIPE_FWD_EN
            pend2 = fwd_pend_i[i];
            fdat2 = fwd_wdata_i[DATA_W*i +: DATA_W];
`endif
         end
      end
   end

`ifndef ID_PIPE_FWD_EN
   // forwarded data and pending flags play no role without forwarding
   logic unused_fwd;
   assign unused_fwd = ^{fwd_wdata_i, fwd_pend_i};
`endif

   // --------------------------------------------------- operands and hazard
   logic [DATA_W-1:0] opnd1, opnd2;
   logic              haz1, haz2, hazard, accept;

   always_comb begin
      if (!rd1)              opnd1 = imm1;
      else if (rs == 5'd0)   opnd1 = '0;
`ifdef ID_PIPE_FWD_EN
      else if (hit1)         opnd1 = fdat1;
`endif
      else                   opnd1 = reg1_data_i;

      if (!rd2)              opnd2 = imm2;
      else if (rt == 5'd0)   opnd2 = '0;
`ifdef ID_PIPE_FWD_EN
      else if (hit2)         opnd2 = fdat2;
`endif
      else                   opnd2 = reg2_data_i;
   end

`ifdef ID_PIPE_FWD_EN
   assign haz1 = rd1 && (rs != 5'd0) && hit1 && pend1;
   assign haz2 = rd2 && (rt != 5'd0) && hit2 && pend2;
`else
   assign haz1 = rd1 && (rs != 5'd0) && hit1;
   assign haz2 = rd2 && (rt != 5'd0) && hit2;
`endif
   assign hazard   = haz1 || haz2;
   assign stall_o  = in_valid && hazard;
   assign in_ready = !hazard && (!vld_q || out_ready);
   assign accept   = in_valid && in_ready;

   // -------------------------------------------------------- payload slot
   always_comb begin
      vld_d = vld_q;
      pay_d = pay_q;
      if (accept) begin
         vld_d         = 1'b1;
         pay_d.aluop   = dec_aluop;
         pay_d.alusel  = dec_alusel;
         pay_d.reg1    = opnd1;
         pay_d.reg2    = opnd2;
         pay_d.wd      = dec_wd;
         pay_d.wreg    = dec_wreg;
         pay_d.pc      = pc_i;
         pay_d.invalid = dec_inv;
      end else if (out_ready) begin
         // drained with nothing new: bubble, payload left as is
         vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         vld_q <= 1'b0;
         pay_q <= '0;
      end else begin
         vld_q <= vld_d;
         pay_q <= pay_d;
      end
   end

   assign out_valid      = vld_q;
   assign aluop_o        = pay_q.aluop;
   assign alusel_o       = pay_q.alusel;
   assign reg1_o         = pay_q.reg1;
   assign reg2_o         = pay_q.reg2;
   assign wd_o           = pay_q.wd;
   assign wreg_o         = pay_q.wreg;
   assign pc_o           = pay_q.pc;
   assign inst_invalid_o = pay_q.invalid;

endmodule
